multicycle_controller: RTL and testbench

Main control FSM of the multi-cycle MIPS core; sits directly upstream of the ALU control decoder and the ALU.
- Sequences every instruction through fetch / decode / execute / memory / writeback.
- Drives datapath mux selects, write enables and the ALUOp code that the ALU control decoder turns into the ALU's ALUConf/Sign.
- Stalls on a memory-ready handshake.

---
 rtl/cpu_ctrl_pkg.sv | 97 +++++++++
 rtl/ctrl_output_decode.sv | 99 +++++++++
 rtl/multicycle_controller.sv | 106 ++++++++++
 tb/tb_multicycle_controller.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the multi-cycle MIPS core: FSM states,
// ALUOp codes, instruction field constants and datapath mux selects.
package cpu_ctrl_pkg;

    localparam int CTRL_ALUOP_W = 4;
    localparam int CTRL_STATE_W = 4;

    typedef enum logic [CTRL_STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_ALU_WB    = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_READ  = 4'd6,
        S_LOAD_WB   = 4'd7,
        S_MEM_WRITE = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_JUMP_REG  = 4'd11
    } state_t;

    typedef enum logic [CTRL_ALUOP_W-1:0] {
        ALUOP_ADD   = 4'd0,
        ALUOP_SUB   = 4'd1,
        ALUOP_RTYPE = 4'd2,
        ALUOP_AND   = 4'd3,
        ALUOP_OR    = 4'd4,
        ALUOP_SLT   = 4'd5,
        ALUOP_SLTU  = 4'd6
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] MEMTOREG_ALU = 2'd0;
    localparam logic [1:0] MEMTOREG_MDR = 2'd1;
    localparam logic [1:0] MEMTOREG_PC  = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_REG   = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic       lui_op;
        logic [1:0] pc_source;
        aluop_t     alu_op;
    } ctrl_t;

    function automatic logic is_shift_funct(input logic [5:0] funct);
        return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational decode of the FSM state (plus the held IR fields) into the
// datapath control bundle.
module ctrl_output_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl            = '0;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = MEMTOREG_ALU;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.pc_source  = PCSRC_ALU;
        ctrl.alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                // PC and IR only load on the cycle memory actually delivers.
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SL2;
                ctrl.ext_op    = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = is_shift_funct(funct) ? SRCA_SHAMT : SRCA_REG;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = SRCA_REG;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = !((op_code == OP_ANDI) || (op_code == OP_ORI));
                ctrl.lui_op    = (op_code == OP_LUI);
                case (op_code)
                    OP_ANDI:  ctrl.alu_op = ALUOP_AND;
                    OP_ORI:   ctrl.alu_op = ALUOP_OR;
                    OP_SLTI:  ctrl.alu_op = ALUOP_SLT;
                    OP_SLTIU: ctrl.alu_op = ALUOP_SLTU;
                    default:  ctrl.alu_op = ALUOP_ADD;
                endcase
            end
            S_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = (op_code == OP_RTYPE) ? REGDST_RD : REGDST_RT;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = SRCA_REG;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = 1'b1;
            end
            S_MEM_READ: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_LOAD_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = MEMTOREG_MDR;
            end
            S_MEM_WRITE: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = SRCA_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                if (op_code == OP_JAL) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = REGDST_RA;
                    ctrl.mem_to_reg = MEMTOREG_PC;
                end
            end
            S_JUMP_REG: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_REG;
                if (funct == FN_JALR) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = REGDST_RD;
                    ctrl.mem_to_reg = MEMTOREG_PC;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch/decode/
// execute/memory/writeback and stalls on the memory-ready handshake.
module multicycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ExtOp,
    output logic               LuiOp,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp
);

    logic [STATE_W-1:0] state_q;
    state_t             state;
    state_t             next_state;
    ctrl_t              dec_ctrl;
    ctrl_t              ctrl;

    assign state = state_t'(state_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= STATE_W'(S_FETCH);
        end else begin
            state_q <= STATE_W'(next_state);
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:     next_state = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (OpCode)
                    OP_RTYPE: next_state = ((Funct == FN_JR) || (Funct == FN_JALR))
                                           ? S_JUMP_REG : S_EXEC_R;
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_LUI: next_state = S_EXEC_I;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J, OP_JAL: next_state = S_JUMP;
                    // Unknown opcodes retire as a NOP; PC was already bumped in FETCH.
                    default:      next_state = S_FETCH;
                endcase
            end
            S_EXEC_R:    next_state = S_ALU_WB;
            S_EXEC_I:    next_state = S_ALU_WB;
            S_MEM_ADDR: begin
                if (OpCode == OP_LW) begin
                    next_state = S_MEM_READ;
                end else if (OpCode == OP_SW) begin
                    next_state = S_MEM_WRITE;
                end
            end
            S_MEM_READ:  next_state = MemReady ? S_LOAD_WB : S_MEM_READ;
            S_MEM_WRITE: next_state = MemReady ? S_FETCH : S_MEM_WRITE;
            default:     next_state = S_FETCH;
        endcase
    end

    ctrl_output_decode u_decode (
        .state     (state),
        .op_code   (OpCode),
        .funct     (Funct),
        .mem_ready (MemReady),
        .ctrl      (dec_ctrl)
    );

    // Outputs are forced low combinationally while reset is held.
    assign ctrl = reset ? dec_ctrl : '0;

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ExtOp       = ctrl.ext_op;
    assign LuiOp       = ctrl.lui_op;
    assign PCSource    = ctrl.pc_source;
    assign ALUOp       = ALUOP_W'(ctrl.alu_op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instructions plus a random
// instruction stream, each cycle checked against a per-instruction cycle table.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] OpCode = 6'h00;
    logic [5:0] Funct = 6'h00;
    logic       MemReady = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
    logic       ExtOp, LuiOp;
    logic [3:0] ALUOp;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp),
        .LuiOp(LuiOp), .PCSource(PCSource), .ALUOp(ALUOp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, rw;
        logic [1:0] rdst, m2r, srca, srcb;
        logic       ext, lui;
        logic [1:0] pcsrc;
        logic [3:0] aluop;
    } vec_t;

    vec_t obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                  RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuiOp, PCSource, ALUOp};

    int   checks = 0;
    int   failures = 0;
    vec_t exp_q[$];
    bit   rdy_q[$];

    task automatic check(input string tag, input vec_t expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input vec_t v, input bit r);
        exp_q.push_back(v);
        rdy_q.push_back(r);
    endtask

    // Expected cycle-by-cycle control vectors for one whole instruction.
    task automatic build(input logic [5:0] op, input logic [5:0] fn,
                         input int fstall, input int mstall);
        vec_t v;
        for (int i = 0; i < fstall; i++) begin
            v = '0; v.mrd = 1; v.srcb = 2'd1; push(v, 1'b0);
        end
        v = '0; v.mrd = 1; v.irw = 1; v.pcw = 1; v.srcb = 2'd1; push(v, 1'b1);
        v = '0; v.srcb = 2'd3; v.ext = 1; push(v, 1'b1);
        case (op)
            6'h00: begin
                if (fn == 6'h08 || fn == 6'h09) begin
                    v = '0; v.pcw = 1; v.pcsrc = 2'd3;
                    if (fn == 6'h09) begin v.rw = 1; v.rdst = 2'd1; v.m2r = 2'd2; end
                    push(v, 1'b1);
                end else begin
                    v = '0; v.srca = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'd2 : 2'd1;
                    v.aluop = 4'd2; push(v, 1'b1);
                    v = '0; v.rw = 1; v.rdst = 2'd1; push(v, 1'b1);
                end
            end
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f: begin
                v = '0; v.srca = 2'd1; v.srcb = 2'd2;
                v.ext = !(op == 6'h0c || op == 6'h0d);
                v.lui = (op == 6'h0f);
                v.aluop = (op == 6'h0c) ? 4'd3 : (op == 6'h0d) ? 4'd4 :
                          (op == 6'h0a) ? 4'd5 : (op == 6'h0b) ? 4'd6 : 4'd0;
                push(v, 1'b1);
                v = '0; v.rw = 1; push(v, 1'b1);
            end
            6'h23, 6'h2b: begin
                v = '0; v.srca = 2'd1; v.srcb = 2'd2; v.ext = 1; push(v, 1'b1);
                for (int i = 0; i <= mstall; i++) begin
                    v = '0; v.iord = 1;
                    if (op == 6'h23) v.mrd = 1; else v.mwr = 1;
                    push(v, i == mstall);
                end
                if (op == 6'h23) begin
                    v = '0; v.rw = 1; v.m2r = 2'd1; push(v, 1'b1);
                end
            end
            6'h04: begin
                v = '0; v.srca = 2'd1; v.aluop = 4'd1; v.pcwc = 1; v.pcsrc = 2'd1;
                push(v, 1'b1);
            end
            6'h02, 6'h03: begin
                v = '0; v.pcw = 1; v.pcsrc = 2'd2;
                if (op == 6'h03) begin v.rw = 1; v.rdst = 2'd2; v.m2r = 2'd2; end
                push(v, 1'b1);
            end
            default: ;
        endcase
    endtask

    // Plays up to n queued cycles (all when n < 0); entered and left at posedge+1.
    task automatic run(input string tag, input int n);
        vec_t v;
        bit   r;
        int   k = 0;
        while (exp_q.size() > 0 && (n < 0 || k < n)) begin
            v = exp_q.pop_front();
            r = rdy_q.pop_front();
            MemReady = r;
            #1;
            check(tag, v);
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input int fstall, input int mstall);
        OpCode = op;
        Funct  = fn;
        build(op, fn, fstall, mstall);
        run(tag, -1);
    endtask

    logic [5:0] op_tab [16] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09,
                                6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h3f};
    logic [5:0] fn_tab [8]  = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h2a, 6'h22};

    initial begin
        reset = 1'b0;
        MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_idle", '0);
        reset = 1'b1;

        instr("add", 6'h00, 6'h20, 0, 0);
        instr("lw_stall", 6'h23, 6'h00, 0, 3);
        instr("beq", 6'h04, 6'h00, 0, 0);
        instr("jal", 6'h03, 6'h00, 0, 0);
        instr("illegal", 6'h3f, 6'h00, 0, 0);
        instr("sll", 6'h00, 6'h00, 1, 0);
        instr("jalr", 6'h00, 6'h09, 0, 0);
        instr("sw_stall", 6'h2b, 6'h00, 0, 2);
        instr("lui", 6'h0f, 6'h00, 0, 0);

        // Abort a load while it waits in the memory-read phase.
        OpCode = 6'h23;
        Funct  = 6'h00;
        build(6'h23, 6'h00, 0, 5);
        run("lw_pre_reset", 4);
        exp_q.delete();
        rdy_q.delete();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MemReady = 1'($urandom_range(0, 1));
            #1;
            check("in_reset", '0);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        instr("after_reset", 6'h2b, 6'h00, 0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = op_tab[$urandom_range(0, 15)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 7)];
            instr("random", op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
